// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the error-response FSM states used by the SoC's AHB slaves.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] ST_OKAY = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    typedef struct packed {
        logic [3:0] mask;
        logic       misaligned;
    } bytemask_t;

endpackage

// File: rtl/ahb_bram_bridge_if.sv
// AHB-Lite signal bundle between a master/interconnect and the BRAM bridge slave.
interface ahb_bram_bridge_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_bytemask_dec.sv
// Combinational HSIZE/HADDR[1:0] to byte-lane mask decoder with misalignment flag.
module ahb_bytemask_dec
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output bytemask_t  dec_c
);

    always_comb begin
        dec_c = '0;
        case (size)
            HSIZE_BYTE: begin
                dec_c.mask = 4'(4'b0001 << addr_lo);
            end
            HSIZE_HALF: begin
                dec_c.mask       = addr_lo[1] ? 4'b1100 : 4'b0011;
                dec_c.misaligned = addr_lo[0];
            end
            // word and oversize both cover all lanes
            default: begin
                dec_c.mask       = 4'b1111;
                dec_c.misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/ahb_bram_bridge.sv
// Zero-wait AHB-Lite slave for a dual-port BRAM with write-to-read forwarding.
// Optional ERROR responses for bad size/alignment/range: define AHB_BRAM_ERROR_RESP_EN.
module ahb_bram_bridge
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clka,
    input  logic                  rsta,
    ahb_bram_bridge_if.slave      ahb,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    logic                  accept_c;
    logic                  err_c;
    logic                  wr_start_c;
    logic                  raw_c;
    logic [ADDR_WIDTH-1:0] word_addr_c;
    bytemask_t             dec_c;
    logic                  unused_c;

    logic                  wr_pend;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [3:0]            wr_mask;
    logic                  fwd_valid;
    logic [3:0]            fwd_mask;
    logic [31:0]           fwd_data;

    ahb_bytemask_dec u_dec (
        .size    (ahb.HSIZE),
        .addr_lo (ahb.HADDR[1:0]),
        .dec_c   (dec_c)
    );

    assign accept_c    = ahb.HSEL && ahb.HTRANS[1] && ahb.HREADY;
    assign word_addr_c = ahb.HADDR[ADDR_WIDTH+1:2];
    assign wr_start_c  = accept_c && ahb.HWRITE && !err_c;
    // read address phase hitting the word whose write commits this cycle
    assign raw_c       = wr_pend && accept_c && !ahb.HWRITE && !err_c
                         && (word_addr_c == wr_addr);

`ifdef AHB_BRAM_ERROR_RESP_EN
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       hreadyout_q;
    logic       hresp_q;

    assign err_c = accept_c && ((ahb.HSIZE > HSIZE_WORD) || dec_c.misaligned
                                || (ahb.HADDR[31:ADDR_WIDTH+2] != '0));
    assign unused_c = ahb.HTRANS[0];

    // error FSM state register with registered response outputs
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q     <= ST_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= (state_d != ST_ERR1);
            hresp_q     <= (state_d != ST_OKAY) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    // two-cycle ERROR sequence; ERR2 accepts a new transfer like OKAY
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OKAY, ST_ERR2: state_d = err_c ? ST_ERR1 : ST_OKAY;
            ST_ERR1:          state_d = ST_ERR2;
            default:          state_d = ST_OKAY;
        endcase
    end

    assign ahb.HREADYOUT = hreadyout_q;
    assign ahb.HRESP     = hresp_q;
`else
    assign err_c         = 1'b0;
    assign unused_c      = ^{ahb.HTRANS[0], dec_c.misaligned, ahb.HADDR[31:ADDR_WIDTH+2]};
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = HRESP_OKAY;
`endif

    // write pipeline and forwarding capture
    always_ff @(posedge clka) begin
        if (rsta) begin
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_mask   <= '0;
            fwd_valid <= 1'b0;
            fwd_mask  <= '0;
            fwd_data  <= '0;
        end else begin
            wr_pend   <= wr_start_c;
            fwd_valid <= raw_c;
            if (wr_start_c) begin
                wr_addr <= word_addr_c;
                wr_mask <= dec_c.mask;
            end
            if (raw_c) begin
                fwd_mask <= bram_wea;
                fwd_data <= ahb.HWDATA;
            end
        end
    end

    assign bram_addra = wr_addr;
    assign bram_dina  = ahb.HWDATA;
    assign bram_wea   = (wr_pend && !rsta) ? wr_mask : 4'b0000;
    assign bram_addrb = word_addr_c;

    // merge forwarded lanes over the stale RAM word
    always_comb begin
        ahb.HRDATA = bram_doutb;
        for (int i = 0; i < 4; i++) begin
            if (fwd_valid && fwd_mask[i]) begin
                ahb.HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// Directed self-checking bench for ahb_bram_bridge with a behavioural 1-cycle-latency BRAM.
module tb_ahb_bram_bridge;
    import ahb_pkg::*;

    localparam int unsigned AW = 14;

    logic          clka = 1'b0;
    logic          rsta;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addrb;
    logic [31:0]   bram_doutb;
    logic [31:0]   mem [0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clka = ~clka;

    ahb_bram_bridge_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clka       (clka),
        .rsta       (rsta),
        .ahb        (bus.slave),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_wea   (bram_wea),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    // read-first RAM: a same-edge read returns the pre-write word
    always @(posedge clka) begin
        for (int i = 0; i < 4; i++) begin
            if (bram_wea[i]) mem[bram_addra][8*i +: 8] <= bram_dina[8*i +: 8];
        end
        bram_doutb <= mem[bram_addrb];
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_ph();
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = HSIZE_WORD;
        bus.HADDR  = 32'h0;
    endtask

    task automatic wr_ph(input logic [31:0] addr, input logic [2:0] size);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
    endtask

    task automatic rd_ph(input logic [31:0] addr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = HSIZE_WORD;
        bus.HADDR  = addr;
    endtask

    initial begin
        rsta = 1'b1;
        bus.HWDATA = 32'h0;
        idle_ph();
        tick(); tick();
        rsta = 1'b0;
        settle();
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("rst_hresp",     32'(bus.HRESP),     32'h0);
        chk("rst_wea",       32'(bram_wea),      32'h0);
        chk("rst_addra",     32'(bram_addra),    32'h0);

        // word write 0x12345678 to 0x10, read two cycles later
        wr_ph(32'h10, HSIZE_WORD);
        tick(); idle_ph(); bus.HWDATA = 32'h12345678; settle();
        chk("w1_wea",   32'(bram_wea),   32'hF);
        chk("w1_addra", 32'(bram_addra), 32'h4);
        chk("w1_dina",  bram_dina,       32'h12345678);
        tick(); rd_ph(32'h10); settle();
        chk("r1_addrb", 32'(bram_addrb), 32'h4);
        tick(); idle_ph(); settle();
        chk("r1_hrdata", bus.HRDATA, 32'h12345678);

        // byte write 0xAB to 0x13 over 0x12345678
        tick(); wr_ph(32'h13, HSIZE_BYTE);
        tick(); idle_ph(); bus.HWDATA = 32'hAB000000; settle();
        chk("wb_wea",   32'(bram_wea),   32'h8);
        chk("wb_addra", 32'(bram_addra), 32'h4);
        tick(); rd_ph(32'h10);
        tick(); idle_ph(); settle();
        chk("rb_hrdata", bus.HRDATA, 32'hAB345678);

        // back-to-back word write then read of the same word: full forward
        tick(); wr_ph(32'h20, HSIZE_WORD);
        tick(); rd_ph(32'h20); bus.HWDATA = 32'hDEADBEEF; settle();
        chk("fw_wea",   32'(bram_wea),   32'hF);
        chk("fw_addra", 32'(bram_addra), 32'h8);
        tick(); rd_ph(32'h20); settle();
        chk("fw_hrdata", bus.HRDATA, 32'hDEADBEEF);
        tick(); idle_ph(); settle();
        chk("fw_ram_hrdata", bus.HRDATA, 32'hDEADBEEF);

        // halfword forward over 0x11112222
        tick(); wr_ph(32'h20, HSIZE_WORD);
        tick(); idle_ph(); bus.HWDATA = 32'h11112222;
        tick(); wr_ph(32'h22, HSIZE_HALF);
        tick(); rd_ph(32'h20); bus.HWDATA = 32'hCAFE0000; settle();
        chk("hf_wea", 32'(bram_wea), 32'hC);
        tick(); rd_ph(32'h10); settle();
        chk("hf_hrdata", bus.HRDATA, 32'hCAFE2222);
        tick(); idle_ph(); settle();
        chk("fwd_clears", bus.HRDATA, 32'hAB345678);

        // write data phase with a read of a different word: no forward
        tick(); wr_ph(32'h30, HSIZE_WORD);
        tick(); rd_ph(32'h10); bus.HWDATA = 32'h55555555;
        tick(); idle_ph(); settle();
        chk("nofwd_hrdata", bus.HRDATA, 32'hAB345678);

        // reset during a write data phase drops the write
        tick(); wr_ph(32'h10, HSIZE_WORD);
        tick(); idle_ph(); bus.HWDATA = 32'hFFFFFFFF; rsta = 1'b1; settle();
        chk("rstw_wea", 32'(bram_wea), 32'h0);
        tick(); rsta = 1'b0; settle();
        chk("rstw_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("rstw_hresp",     32'(bus.HRESP),     32'h0);
        chk("rstw_wea2",      32'(bram_wea),      32'h0);
        chk("rstw_addra",     32'(bram_addra),    32'h0);
        rd_ph(32'h10);
        tick(); idle_ph(); settle();
        chk("rstw_mem", bus.HRDATA, 32'hAB345678);

        // misaligned word write to 0x02
        tick(); wr_ph(32'h02, HSIZE_WORD);
        tick(); idle_ph(); bus.HWDATA = 32'h77777777; settle();
`ifdef AHB_BRAM_ERROR_RESP_EN
        chk("err1_hreadyout", 32'(bus.HREADYOUT), 32'h0);
        chk("err1_hresp",     32'(bus.HRESP),     32'h1);
        chk("err1_wea",       32'(bram_wea),      32'h0);
        tick(); rd_ph(32'h10); settle();
        chk("err2_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("err2_hresp",     32'(bus.HRESP),     32'h1);
        chk("err2_wea",       32'(bram_wea),      32'h0);
        tick(); idle_ph(); settle();
        chk("post_hresp",     32'(bus.HRESP),     32'h0);
        chk("post_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("post_hrdata",    bus.HRDATA,         32'hAB345678);
`else
        chk("mis_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("mis_hresp",     32'(bus.HRESP),     32'h0);
        chk("mis_wea",       32'(bram_wea),      32'hF);
        chk("mis_addra",     32'(bram_addra),    32'h0);
        tick(); rd_ph(32'h10); settle();
        chk("mis_wea_off",   32'(bram_wea),      32'h0);
        tick(); idle_ph(); settle();
        chk("mis_hrdata",    bus.HRDATA,         32'hAB345678);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_bram_bridge.md
Name: ahb_bram_bridge

Overview:
- AHB-Lite slave placed directly upstream of the SoC's dual-port block RAM.
- Converts Cortex-M0 bus transfers into port-A byte-enabled writes and port-B reads for the RAM.
- Zero-wait-state operation; the RAM has 1-cycle read latency.
- Resolves the read-after-write hazard the RAM exhibits on back-to-back accesses to the same word.

Parameters:
- ADDR_WIDTH, 14, word-address width of the attached RAM (RAM depth = 2**ADDR_WIDTH words).

Ports:
- clka  in  1  single clock, shared with the RAM
- rsta  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus ready from the interconnect
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- bram_addra  out  ADDR_WIDTH  RAM write address
- bram_dina  out  32  RAM write data
- bram_wea  out  4  RAM byte write enables
- bram_addrb  out  ADDR_WIDTH  RAM read address
- bram_doutb  in  32  RAM read data, registered 1 cycle after bram_addrb

Behaviour:
- Accept condition: HSEL && HTRANS[1] && HREADY. IDLE and BUSY transfers are ignored and produce an OKAY response.
- Byte mask from HSIZE / HADDR[1:0]:
  - size 0: one bit at HADDR[1:0].
  - size 1: 4'b0011 or 4'b1100, selected by HADDR[1].
  - size 2: 4'b1111.
- Write, address phase: register word address HADDR[ADDR_WIDTH+1:2], the byte mask and a write-pending flag.
- Write, data phase (next cycle):
  - bram_addra = registered address.
  - bram_dina = HWDATA, passed through combinationally.
  - bram_wea = mask while write-pending is set, else 0.
  - The RAM commits the write at the end of this cycle.
- Read:
  - bram_addrb = HADDR[ADDR_WIDTH+1:2], driven combinationally at all times.
  - bram_doutb is valid in the data phase. HRDATA is the full word; the master selects the lanes it needs.
- HREADYOUT is 1 in every state except ERR1. There are no wait states on the OKAY path.
- RAW hazard case: a write data phase to word A in cycle N, with an accepted read address phase to A in the same cycle N.
  - The RAM returns the pre-write value in cycle N+1.
  - The bridge captures fwd_valid=1, fwd_mask=bram_wea and fwd_data=HWDATA at the end of cycle N.
  - In cycle N+1, each HRDATA byte is fwd_data where fwd_mask is set, and bram_doutb otherwise.
  - fwd_valid clears after one cycle.
- A read of a different word, or a write followed by a write, never forwards.
- Reset (rsta=1 at a clka edge):
  - Clears write-pending, fwd_valid and error state.
  - bram_wea is forced to 0 in the reset cycle, so a write whose data phase coincides with reset is dropped.
  - Outputs after reset: HREADYOUT=1, HRESP=0, bram_wea=0, bram_addra=0.
- HRDATA is unspecified during write data phases.

Optional Feature:
- Macro: AHB_BRAM_ERROR_RESP_EN.
- Defined, an accepted transfer returns the standard two-cycle ERROR response when:
  - HSIZE > 2, or
  - the address is misaligned (size 1 with HADDR[0]=1; size 2 with HADDR[1:0]≠0), or
  - HADDR[31:ADDR_WIDTH+2] ≠ 0.
- Error state machine: OKAY → ERR1 (HREADYOUT=0, HRESP=1) → ERR2 (HREADYOUT=1, HRESP=1) → OKAY.
- In the error case, no RAM write is issued and forwarding is not armed.
- A new transfer presented during ERR2 is accepted normally.
- Undefined: HRESP tied 0, HREADYOUT tied 1, misaligned low bits ignored, size > 2 treated as word, upper address bits ignored (aliasing).

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE encodings (BYTE, HALF, WORD);
  - HRESP encodings;
  - error-FSM state constants.
- One sub-module, ahb_bytemask_dec: combinational HSIZE/HADDR[1:0] → 4-bit mask plus misalignment flag. It is reused by other AHB slaves in the SoC.

Test Plan:
- Word write 0x12345678 to 0x0000_0010, then a read of 0x10 two cycles later → bram_wea=4'hF with bram_addra=4 in the data phase; HRDATA=0x12345678.
- Byte write 0xAB to 0x13 (HWDATA=0xAB000000) over an existing 0x12345678 → bram_wea=4'b1000; a later read returns 0xAB345678.
- Back-to-back write 0xDEADBEEF to 0x20, then read of 0x20 in the next cycle (RAM still old value 0x0) → HRDATA=0xDEADBEEF via forwarding.
- Halfword write 0xCAFE to 0x22 then an immediate read of 0x20, old word 0x11112222 → HRDATA=0xCAFE2222 (partial-lane forward).
- rsta asserted during the data phase of a write → bram_wea=0, memory unchanged, HREADYOUT=1 and HRESP=0 after reset.
- With AHB_BRAM_ERROR_RESP_EN: word write to 0x02 → HREADYOUT=0/HRESP=1 for one cycle, then HREADYOUT=1/HRESP=1; bram_wea stays 0.
